// File: rtl/bomberman_pkg.sv
// Shared encodings for grid-based sprite movers: directions, FSM states and
// collision-veto bit positions.
package bomberman_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    SNAP = 2'd2
  } state_e;

  localparam int unsigned BLK_L = 0;
  localparam int unsigned BLK_R = 1;
  localparam int unsigned BLK_U = 2;
  localparam int unsigned BLK_D = 3;

endpackage

// File: rtl/step_timer.sv
// Step-period divider: counts while running, strobes tick on the last count
// of each period and wraps to zero.
module step_timer #(
  parameter int unsigned STEP_TICKS = 1400000,
  parameter int unsigned CNT_W      = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/grid_sprite_mover.sv
// Tile-aware sprite mover: one pixel per step period inside the play field,
// snapping to the tile grid on release/turn, plus sprite hit-test for the ROM.
module grid_sprite_mover
  import bomberman_pkg::*;
#(
  parameter int unsigned X_MIN      = 144,
  parameter int unsigned X_MAX      = 740,
  parameter int unsigned Y_MIN      = 144,
  parameter int unsigned Y_MAX      = 500,
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 16,
  parameter int unsigned TILE       = 16,
  parameter int unsigned STEP_TICKS = 1400000,
  parameter int unsigned CNT_W      = 21,
  parameter int unsigned INIT_X     = 144,
  parameter int unsigned INIT_Y     = 400
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       L,
  input  logic                       R,
  input  logic                       U,
  input  logic                       D,
  input  logic                       respawn,
  input  logic                       game_over,
  input  logic [3:0]                 blocked,
  input  logic [9:0]                 v_x,
  input  logic [9:0]                 v_y,
  output logic [9:0]                 pos_x,
  output logic [9:0]                 pos_y,
  output logic [1:0]                 facing,
  output logic                       moving,
  output logic                       aligned,
  output logic                       step_pulse,
  output logic                       sprite_on,
  output logic [$clog2(SPR_W)-1:0]   sprite_col,
  output logic [$clog2(SPR_H)-1:0]   sprite_row
);

  localparam logic [9:0] P_XMIN  = 10'(X_MIN);
  localparam logic [9:0] P_XLIM  = 10'(X_MAX - SPR_W);
  localparam logic [9:0] P_YMIN  = 10'(Y_MIN);
  localparam logic [9:0] P_YLIM  = 10'(Y_MAX - SPR_H);
  localparam logic [9:0] P_INITX = 10'(INIT_X);
  localparam logic [9:0] P_INITY = 10'(INIT_Y);
  localparam logic [9:0] P_TMASK = 10'(TILE - 1);
  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);

  state_e     r_state, w_state_nx;
  dir_e       r_facing, w_facing_nx, w_req_dir;
  logic [9:0] r_pos_x, r_pos_y, w_pos_x_nx, w_pos_y_nx;
  logic       r_step_pulse;
  logic       w_req_valid, w_cur_held, w_change, w_aligned;
  logic       w_blk, w_in_bounds, w_legal, w_attempt, w_step, w_tick;
  logic       w_run, w_clear;
  logic [9:0] w_dx, w_dy;

  step_timer #(
    .STEP_TICKS(STEP_TICKS),
    .CNT_W     (CNT_W)
  ) u_step_timer (
    .clk  (clk),
    .reset(reset),
    .run  (w_run),
    .clear(w_clear),
    .tick (w_tick)
  );

  assign w_run   = (r_state != IDLE);
  assign w_clear = (r_state == IDLE) || respawn || game_over;

  always_comb begin
    w_req_valid = L || R || U || D;
    w_req_dir   = DIR_D;
    if (L)      w_req_dir = DIR_L;
    else if (R) w_req_dir = DIR_R;
    else if (U) w_req_dir = DIR_U;
  end

  assign w_aligned = (((r_pos_x - P_XMIN) & P_TMASK) == '0) &&
                     (((r_pos_y - P_YMIN) & P_TMASK) == '0);

  always_comb begin
    w_cur_held  = D;
    w_blk       = blocked[BLK_D];
    w_in_bounds = (r_pos_y < P_YLIM);
    unique case (r_facing)
      DIR_L: begin w_cur_held = L; w_blk = blocked[BLK_L]; w_in_bounds = (r_pos_x > P_XMIN); end
      DIR_R: begin w_cur_held = R; w_blk = blocked[BLK_R]; w_in_bounds = (r_pos_x < P_XLIM); end
      DIR_U: begin w_cur_held = U; w_blk = blocked[BLK_U]; w_in_bounds = (r_pos_y > P_YMIN); end
      DIR_D: begin w_cur_held = D; w_blk = blocked[BLK_D]; w_in_bounds = (r_pos_y < P_YLIM); end
    endcase
  end

  assign w_change = !w_cur_held || (w_req_dir != r_facing);
  assign w_legal  = !w_blk && !game_over && w_in_bounds;

  // An aligned turn or stop consumes no step, so the sprite never leaves the grid.
  always_comb begin
    w_state_nx  = r_state;
    w_facing_nx = r_facing;
    w_attempt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_valid) begin
          w_state_nx  = MOVE;
          w_facing_nx = w_req_dir;
        end
      end
      MOVE: begin
        if (w_change && w_aligned) begin
          if (w_req_valid) w_facing_nx = w_req_dir;
          else             w_state_nx  = IDLE;
        end else begin
          if (w_change) w_state_nx = SNAP;
          w_attempt = w_tick;
        end
      end
      SNAP: begin
        if (w_aligned) begin
          if (w_req_valid) begin
            w_state_nx  = MOVE;
            w_facing_nx = w_req_dir;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_attempt = w_tick;
          if (w_tick && !w_legal) w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (game_over) begin
      w_state_nx  = IDLE;
      w_facing_nx = r_facing;
      w_attempt   = 1'b0;
    end
  end

  assign w_step = w_attempt && w_legal;

  always_comb begin
    w_pos_x_nx = r_pos_x;
    w_pos_y_nx = r_pos_y;
    if (w_step) begin
      unique case (r_facing)
        DIR_L: w_pos_x_nx = r_pos_x - 10'd1;
        DIR_R: w_pos_x_nx = r_pos_x + 10'd1;
        DIR_U: w_pos_y_nx = r_pos_y - 10'd1;
        DIR_D: w_pos_y_nx = r_pos_y + 10'd1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_facing     <= DIR_D;
      r_pos_x      <= P_INITX;
      r_pos_y      <= P_INITY;
      r_step_pulse <= 1'b0;
    end else if (respawn) begin
      r_state      <= IDLE;
      r_facing     <= DIR_D;
      r_pos_x      <= P_INITX;
      r_pos_y      <= P_INITY;
      r_step_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_facing     <= w_facing_nx;
      r_pos_x      <= w_pos_x_nx;
      r_pos_y      <= w_pos_y_nx;
      r_step_pulse <= w_step;
    end
  end

  assign w_dx = v_x - r_pos_x;
  assign w_dy = v_y - r_pos_y;

  assign sprite_on  = (v_x >= r_pos_x) && (w_dx < 10'(SPR_W)) &&
                      (v_y >= r_pos_y) && (w_dy < 10'(SPR_H));
  assign sprite_col = w_dx[CW-1:0];
  assign sprite_row = w_dy[RW-1:0];

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign facing     = r_facing;
  assign moving     = (r_state != IDLE);
  assign aligned    = w_aligned;
  assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_grid_sprite_mover.sv
// Scoreboard bench for grid_sprite_mover: expected step positions and state
// probes are queued by the stimulus and checked by an independent monitor.
module tb_grid_sprite_mover;

  logic       clk = 1'b0;
  logic       reset, L, R, U, D, respawn, game_over;
  logic [3:0] blocked;
  logic [9:0] v_x, v_y;
  logic [9:0] pos_x, pos_y;
  logic [1:0] facing;
  logic       moving, aligned, step_pulse, sprite_on;
  logic [3:0] sprite_col, sprite_row;

  grid_sprite_mover #(
    .STEP_TICKS(4),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .L         (L),
    .R         (R),
    .U         (U),
    .D         (D),
    .respawn   (respawn),
    .game_over (game_over),
    .blocked   (blocked),
    .v_x       (v_x),
    .v_y       (v_y),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .facing    (facing),
    .moving    (moving),
    .aligned   (aligned),
    .step_pulse(step_pulse),
    .sprite_on (sprite_on),
    .sprite_col(sprite_col),
    .sprite_row(sprite_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } step_t;

  typedef struct {
    string name;
    int    px, py, fac, mov, al, sp, son, col, row;
    bit    chk_q;
    bit    last;
  } probe_t;

  step_t  q_step[$];
  probe_t q_probe[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    int     cyc;
    step_t  s;
    probe_t p;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (step_pulse === 1'b1) begin
        chk("step_pulse_expected", int'(q_step.size() > 0), 1);
        if (q_step.size() > 0) begin
          s = q_step.pop_front();
          chk("step.pos_x", int'(pos_x), s.x);
          chk("step.pos_y", int'(pos_y), s.y);
        end
      end
      if (q_probe.size() > 0) begin
        p = q_probe.pop_front();
        chk({p.name, ".pos_x"},      int'(pos_x),      p.px);
        chk({p.name, ".pos_y"},      int'(pos_y),      p.py);
        chk({p.name, ".facing"},     int'(facing),     p.fac);
        chk({p.name, ".moving"},     int'(moving),     p.mov);
        chk({p.name, ".aligned"},    int'(aligned),    p.al);
        chk({p.name, ".step_pulse"}, int'(step_pulse), p.sp);
        chk({p.name, ".sprite_on"},  int'(sprite_on),  p.son);
        chk({p.name, ".sprite_col"}, int'(sprite_col), p.col);
        chk({p.name, ".sprite_row"}, int'(sprite_row), p.row);
        if (p.chk_q) chk({p.name, ".pending_steps"}, q_step.size(), 0);
        if (p.last) begin
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      end
      if (cyc > 50000) begin
        n_fail++;
        $display("FAIL timeout: got %0d cycles, expected under 50000", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input string nm, input int px, input int py, input int fac,
                       input int mov, input int al, input int sp, input int son,
                       input int col, input int row, input bit cq = 1'b0,
                       input bit last = 1'b0);
    probe_t p;
    p.name = nm; p.px = px; p.py = py; p.fac = fac; p.mov = mov; p.al = al;
    p.sp = sp; p.son = son; p.col = col; p.row = row; p.chk_q = cq; p.last = last;
    q_probe.push_back(p);
    tick(1);
  endtask

  task automatic push_steps_x(input int from, input int to, input int y);
    step_t s;
    for (int x = from; x <= to; x++) begin
      s.x = x; s.y = y;
      q_step.push_back(s);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!moving) break;
      tick(1);
    end
  endtask

  initial begin : stimulus
    step_t s;
    reset = 1'b1; L = 0; R = 0; U = 0; D = 0; respawn = 0; game_over = 0;
    blocked = '0; v_x = '0; v_y = '0;
    tick(3);
    reset = 1'b0;

    // Reset state and hit-test edges around the spawn tile
    v_x = 10'd144; v_y = 10'd400;
    probe("reset", 144, 400, 3, 0, 1, 0, 1, 0, 0);
    v_x = 10'd159; v_y = 10'd415;
    probe("spr_corner", 144, 400, 3, 0, 1, 0, 1, 15, 15);
    v_x = 10'd160;
    probe("spr_right_out", 144, 400, 3, 0, 1, 0, 0, 0, 15);
    v_x = 10'd143; v_y = 10'd400;
    probe("spr_left_out", 144, 400, 3, 0, 1, 0, 0, 15, 0);
    v_x = '0; v_y = '0;

    // Short press then release: snaps to the next tile at x=160
    push_steps_x(145, 160, 400);
    R = 1; tick(12); R = 0;
    wait_idle(200);
    probe("snap_done", 160, 400, 1, 0, 1, 0, 0, 0, 0, 1'b1);

    // Collision veto on the right
    blocked = 4'b0010; R = 1; tick(12);
    probe("blocked_R", 160, 400, 1, 1, 1, 0, 0, 0, 0);
    R = 0; tick(2); blocked = '0;
    probe("blocked_release", 160, 400, 1, 0, 1, 0, 0, 0, 0, 1'b1);

    // Run to the right wall at x=724 and stop there
    push_steps_x(161, 724, 400);
    R = 1; tick(2300);
    v_x = 10'd730; v_y = 10'd405;
    probe("wall_R", 724, 400, 1, 1, 0, 0, 1, 6, 5, 1'b1);
    v_x = 10'd739; v_y = 10'd415;
    probe("wall_spr_far", 724, 400, 1, 1, 0, 0, 1, 15, 15);
    v_x = 10'd740;
    probe("wall_spr_past", 724, 400, 1, 1, 0, 0, 0, 0, 15);
    v_x = '0; v_y = '0;
    R = 0;
    wait_idle(50);
    probe("wall_snap_idle", 724, 400, 1, 0, 0, 0, 0, 12, 0, 1'b1);
    respawn = 1; tick(1); respawn = 0;
    probe("respawn", 144, 400, 3, 0, 1, 0, 0, 0, 0);

    // L and U together: L wins (and the left wall blocks stepping)
    L = 1; U = 1; tick(10);
    probe("LU_priority", 144, 400, 0, 1, 1, 0, 0, 0, 0, 1'b1);
    L = 0; U = 0; tick(2);

    // Redirect mid-tile: finish at x=160, then climb
    push_steps_x(145, 160, 400);
    s.x = 160; s.y = 399; q_step.push_back(s);
    s.x = 160; s.y = 398; q_step.push_back(s);
    R = 1;
    for (int i = 0; i < 100; i++) begin
      if (pos_x == 10'd150) break;
      tick(1);
    end
    R = 0; U = 1;
    for (int i = 0; i < 200; i++) begin
      if (pos_y == 10'd398) break;
      tick(1);
    end
    probe("turn_up", 160, 398, 2, 1, 0, 1, 0, 0, 2);

    // game_over mid-step period freezes everything
    tick(1); game_over = 1; tick(1);
    probe("game_over", 160, 398, 2, 0, 0, 0, 0, 0, 2);
    tick(8);
    probe("game_over_hold", 160, 398, 2, 0, 0, 0, 0, 0, 2, 1'b1);
    U = 0; game_over = 0; tick(2);
    respawn = 1; tick(1); respawn = 0; tick(1);

    // Asynchronous reset while moving
    push_steps_x(145, 146, 400);
    R = 1;
    for (int i = 0; i < 100; i++) begin
      if (pos_x == 10'd146) break;
      tick(1);
    end
    tick(1);
    reset = 1; #1;
    probe("async_reset", 144, 400, 3, 0, 1, 0, 0, 0, 0);
    R = 0; tick(1); reset = 0; tick(2);
    probe("final", 144, 400, 3, 0, 1, 0, 0, 0, 0, 1'b1, 1'b1);
    tick(10);
  end

endmodule
